cpu_seq_ctrl: RTL and testbench
===============================

# cpu_seq_ctrl

Multi-cycle sequencer for the dCPU core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables for the IR, PC and register file around the instruction decoder and ALU. It runs the req/ack handshakes to instruction and data memory, with a timeout watchdog. It also stops the core on a halt instruction or on a memory fault.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of cycles a memory request is held without ack before the block enters FAULT; must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch word valid this cycle.
- `ir_we`  out  1  latch the fetched word into IR.
- `dec_is_load`, `dec_is_store`, `dec_is_halt`, `dec_reg_we`  in  1 each  decoder flags for the current IR.
- `branch_taken`  in  1  ALU branch/jump result, valid in EXEC.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `dmem_ack`  in  1  data access complete this cycle.
- `rf_we`  out  1  register file write enable.
- `wb_sel`  out  1  writeback source: 0 = ALU, 1 = load data.
- `pc_we`  out  1  update PC.
- `pc_sel`  out  1  next PC: 0 = PC+4, 1 = branch/jump target.
- `halted`  out  1  core stopped by a halt instruction.
- `fault`  out  1  core stopped by a memory timeout.
- `state`  out  3  current state, for debug.
- `cycle_cnt`  out  32  active-cycle counter.
- `instret_cnt`  out  32  retired-instruction counter.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Values 7 and above go to FETCH.
- **Output decoding:** all outputs are decoded from the state register and latched flags, except `ir_we`, which also depends on `imem_ack`.
- **FETCH:**
  - `imem_req`=1 for as long as the block is in FETCH.
  - `imem_ack` high → `ir_we`=1 in the same cycle, and next state is DECODE.
- **DECODE (1 cycle):**
  - Latches `dec_is_load`, `dec_is_store`, `dec_reg_we` into internal registers `l_load`, `l_store`, `l_we`.
  - `dec_is_halt`=1 → HALT; otherwise → EXEC.
- **EXEC (1 cycle):**
  - Latches `branch_taken` into `l_taken`.
  - `l_load` or `l_store` → MEM; otherwise → WB.
- **MEM:**
  - `dmem_req`=1 and `dmem_we`=`l_store` for as long as the block is in MEM.
  - `dmem_ack` high → WB.
- **WB (1 cycle):**
  - `pc_we`=1 and `pc_sel`=`l_taken`.
  - `rf_we`=`l_we` & ~`l_store`.
  - `wb_sel`=`l_load`.
  - Next state is FETCH.
- **HALT:** terminal; `halted`=1, all request and enable outputs are 0; left only by `rst`.
- **FAULT:** terminal; `fault`=1, all request and enable outputs are 0; left only by `rst`.
- **Watchdog:**
  - `wait_cnt` (width `$clog2(MEM_TIMEOUT+1)`) clears on entry to FETCH or MEM.
  - It increments on each request cycle without ack.
  - A request cycle without ack while `wait_cnt`==`MEM_TIMEOUT`-1 → FAULT.
  - An ack arriving on the `MEM_TIMEOUT`-th request cycle is still accepted.
- **Ack outside a request:** `imem_ack`/`dmem_ack` received while the matching request is low is ignored.
- **Reset values:**
  - State = FETCH; latched flags and `wait_cnt` = 0; counters = 0.
  - `imem_req`=1 on the first cycle after reset; every other output is 0 and `state`=0.
- **Reset mid-operation:** `rst` overrides everything, including a pending ack; any request in flight is abandoned.

## Timing
- **Zero-wait memory:** ALU instruction = 4 cycles (F,D,E,W); load/store = 5 cycles (F,D,E,M,W).
- **Wait states:** each memory wait cycle adds 1 cycle.
- **Register file write:** occurs on the clock edge that ends WB; the first fetch of the next instruction begins the following cycle.
- **Halt:** `halted` rises 2 cycles after the `ir_we` of the halt instruction (the DECODE cycle follows, then HALT). The halt instruction is not retired and `pc_we` does not fire.
- **Decoder input stability:** the decoder flags must be stable in DECODE; they are not sampled afterwards.

## Configuration
- **`PERF_COUNTER_EN` defined:**
  - `cycle_cnt` increments every cycle the state is not HALT/FAULT.
  - `instret_cnt` increments in every WB cycle.
  - Both wrap from 2^32-1 to 0 and both clear on `rst`.
- **`PERF_COUNTER_EN` undefined:** both ports are still present and are tied to 0; no counter registers are built.

## Test plan
- **ALU instruction:** reset, then `imem_ack` in the first FETCH cycle; `dec_reg_we`=1, no load/store → `state` sequence 0,1,2,4,0. `rf_we`=1 and `pc_we`=1 only in cycle 4 with `pc_sel`=0; with the macro, `instret_cnt`=1.
- **Load with wait states:** `dec_is_load`=1, `dmem_ack` after 3 request cycles → `dmem_req` high for 3 cycles with `dmem_we`=0. WB then has `wb_sel`=1 and `rf_we`=1; total 7 cycles.
- **Taken branch:** `dec_reg_we`=0, `branch_taken`=1 in EXEC → `rf_we`=0, `pc_sel`=1 in WB.
- **Store:** `dec_is_store`=1 with `dec_reg_we`=1 → `dmem_we`=1 in MEM, and `rf_we`=0 in WB.
- **Timeout:** `MEM_TIMEOUT`=4, `imem_ack` held low → `fault`=1 after 4 request cycles and `imem_req`=0 from then on.
  - Repeat with the ack on the 4th cycle → the fetch completes, no fault.
- **Halt, then reset:** `dec_is_halt`=1 → `halted`=1 and the counters freeze. Assert `rst` for 1 cycle → `state`=0, `halted`=0 and `imem_req`=1 on the next cycle.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle sequencer for the dCPU core.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
// Runs the instruction/data memory req/ack handshakes under a timeout watchdog.
// Stops in HALT on a halt instruction and in FAULT on a memory timeout.
// Optional feature macro: PERF_COUNTER_EN builds the cycle and retired-instruction
// counters. Without it, cycle_cnt and instret_cnt are tied to zero.
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_halt,
  input  logic        dec_reg_we,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  // The last request cycle that may still see an ack before the watchdog fires.
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          l_load_q, l_load_d;
  logic          l_store_q, l_store_d;
  logic          l_we_q, l_we_d;
  logic          l_taken_q, l_taken_d;

  // State, watchdog and latched decoder/ALU flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      l_load_q   <= 1'b0;
      l_store_q  <= 1'b0;
      l_we_q     <= 1'b0;
      l_taken_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      l_load_q   <= l_load_d;
      l_store_q  <= l_store_d;
      l_we_q     <= l_we_d;
      l_taken_q  <= l_taken_d;
    end
  end

  // Next-state logic, flag capture and watchdog counting.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    l_load_d   = l_load_q;
    l_store_d  = l_store_q;
    l_we_d     = l_we_q;
    l_taken_d  = l_taken_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_DECODE: begin
        // Decoder flags are only guaranteed stable here, so capture them now.
        l_load_d  = dec_is_load;
        l_store_d = dec_is_store;
        l_we_d    = dec_reg_we;
        state_d   = dec_is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        l_taken_d = branch_taken;
        state_d   = (l_load_q || l_store_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
    // Every state change starts a fresh watchdog window for the next request.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end
  end

  // Output decode from the state register and latched flags.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = l_store_q;
      end
      S_WB: begin
        pc_we  = 1'b1;
        pc_sel = l_taken_q;
        rf_we  = l_we_q & ~l_store_q;
        wb_sel = l_load_q;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef PERF_COUNTER_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;

  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT && state_q != S_FAULT) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (state_q == S_WB) begin
        instret_cnt_q <= instret_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed testbench for cpu_seq_ctrl (MEM_TIMEOUT = 4).
// Each cycle drives an input vector, then compares a packed output vector:
// {state[2:0], imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, halted, fault}
// Input vector: {imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_is_halt, dec_reg_we, branch_taken}
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0, ir_we;
  logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_halt = 1'b0, dec_reg_we = 1'b0;
  logic        branch_taken = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        rf_we, wb_sel, pc_we, pc_sel, halted, fault;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  int total = 0;
  int bad   = 0;

`ifdef PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_halt(dec_is_halt), .dec_reg_we(dec_reg_we),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .fault(fault), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  function automatic logic [12:0] outs();
    return {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
            pc_we, pc_sel, halted, fault};
  endfunction

  task automatic drive(input logic [6:0] v);
    {imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_is_halt, dec_reg_we, branch_taken} = v;
  endtask

  // Starts and ends on a falling edge, with one rising edge under reset.
  task automatic do_reset();
    rst = 1'b1;
    drive(7'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (outs() !== 13'b000_10_00_00_00_00) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=%b", outs(), 13'b000_10_00_00_00_00);
    end
    total++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [6:0]  vin [5] = '{7'b1000010, 7'b0000010, 7'b0000000, 7'b0000000, 7'b0000000};
    logic [12:0] vexp[5] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b010_00_00_00_00_00, 13'b100_00_00_10_10_00,
                            13'b000_10_00_00_00_00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL alu cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instret_cnt !== (PERF ? 32'd1 : 32'd0) || cycle_cnt !== (PERF ? 32'd5 : 32'd0)) begin
      bad++;
      $display("FAIL alu_cnt got cyc=%0d ret=%0d", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_load_wait();
    // dmem_ack high in FETCH must be ignored (no data request there).
    logic [6:0]  vin [8] = '{7'b1110010, 7'b0010010, 7'b0000000, 7'b0000000,
                            7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000};
    logic [12:0] vexp[8] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b010_00_00_00_00_00, 13'b011_00_10_00_00_00,
                            13'b011_00_10_00_00_00, 13'b011_00_10_00_00_00,
                            13'b100_00_00_11_10_00, 13'b000_10_00_00_00_00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL load cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instret_cnt !== (PERF ? 32'd1 : 32'd0) || cycle_cnt !== (PERF ? 32'd8 : 32'd0)) begin
      bad++;
      $display("FAIL load_cnt got cyc=%0d ret=%0d", cycle_cnt, instret_cnt);
    end
  endtask

  task automatic test_branch();
    // imem_ack in DECODE is ignored; branch_taken dropped in WB checks the latch.
    logic [6:0]  vin [5] = '{7'b1000000, 7'b1000000, 7'b0000001, 7'b0000000, 7'b0000000};
    logic [12:0] vexp[5] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b010_00_00_00_00_00, 13'b100_00_00_00_11_00,
                            13'b000_10_00_00_00_00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL branch cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [6:0]  vin [6] = '{7'b1001010, 7'b0001010, 7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000};
    logic [12:0] vexp[6] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b010_00_00_00_00_00, 13'b011_00_11_00_00_00,
                            13'b100_00_00_00_10_00, 13'b000_10_00_00_00_00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL store cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout();
    // Four unacked fetch cycles, then FAULT; a late ack must not revive it.
    logic [6:0]  vin [6] = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1000000};
    logic [12:0] vexp[6] = '{13'b000_10_00_00_00_00, 13'b000_10_00_00_00_00,
                            13'b000_10_00_00_00_00, 13'b000_10_00_00_00_00,
                            13'b110_00_00_00_00_01, 13'b110_00_00_00_00_01};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL ftimeout cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
    total++;
    if (cycle_cnt !== (PERF ? 32'd4 : 32'd0)) begin
      bad++;
      $display("FAIL ftimeout_cnt got=%0d exp=%0d", cycle_cnt, PERF ? 4 : 0);
    end
  endtask

  task automatic test_fetch_last_ack();
    logic [6:0]  vin [5] = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b1000000, 7'b0000000};
    logic [12:0] vexp[5] = '{13'b000_10_00_00_00_00, 13'b000_10_00_00_00_00,
                            13'b000_10_00_00_00_00, 13'b000_11_00_00_00_00,
                            13'b001_00_00_00_00_00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL flastack cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_data_timeout();
    logic [6:0]  vin [8] = '{7'b1010000, 7'b0010000, 7'b0000000, 7'b0000000,
                            7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000};
    logic [12:0] vexp[8] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b010_00_00_00_00_00, 13'b011_00_10_00_00_00,
                            13'b011_00_10_00_00_00, 13'b011_00_10_00_00_00,
                            13'b011_00_10_00_00_00, 13'b110_00_00_00_00_01};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL dtimeout cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt_reset();
    logic [6:0]  vin [4] = '{7'b1000100, 7'b0000100, 7'b0000000, 7'b1100000};
    logic [12:0] vexp[4] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b101_00_00_00_00_10, 13'b101_00_00_00_00_10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL halt cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
    total++;
    if (cycle_cnt !== (PERF ? 32'd2 : 32'd0) || instret_cnt !== 32'd0) begin
      bad++;
      $display("FAIL halt_cnt got cyc=%0d ret=%0d", cycle_cnt, instret_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(7'b0);
    #1;
    total++;
    if (outs() !== 13'b000_10_00_00_00_00) begin
      bad++;
      $display("FAIL halt_rst got=%b exp=%b", outs(), 13'b000_10_00_00_00_00);
    end
    total++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      bad++;
      $display("FAIL halt_rst_cnt got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    logic [6:0]  vin [4] = '{7'b1010010, 7'b0010010, 7'b0000000, 7'b0000000};
    logic [12:0] vexp[4] = '{13'b000_11_00_00_00_00, 13'b001_00_00_00_00_00,
                            13'b010_00_00_00_00_00, 13'b011_00_10_00_00_00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vin[i]);
      #1;
      total++;
      if (outs() !== vexp[i]) begin
        bad++;
        $display("FAIL rstmid cyc=%0d got=%b exp=%b", i, outs(), vexp[i]);
      end
      @(negedge clk);
    end
    // Reset together with a pending data ack: reset must win.
    rst = 1'b1;
    drive(7'b0100000);
    @(negedge clk);
    rst = 1'b0;
    drive(7'b0);
    #1;
    total++;
    if (outs() !== 13'b000_10_00_00_00_00) begin
      bad++;
      $display("FAIL rstmid_after got=%b exp=%b", outs(), 13'b000_10_00_00_00_00);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_store();
    test_fetch_timeout();
    test_fetch_last_ack();
    test_data_timeout();
    test_halt_reset();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
